// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional `MUL_DIV_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   opB_q, opB_d;
    logic               isDiv_q, isDiv_d;
    logic               negRes_q, negRes_d;
    logic               negA_q, negA_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               isSigned;
    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [2*WIDTH-1:0] mulSum;
    logic [WIDTH:0]     remCand, remDiff;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] prodRes;
    logic [WIDTH-1:0]   quotRes, remRes, dividendOrig;
    logic               lastStep;

    // Operands are reduced to magnitudes at issue; signs are reapplied in FIN.
    assign isSigned = ~op_i[0];
    assign aNeg     = isSigned & a_i[WIDTH-1];
    assign bNeg     = isSigned & b_i[WIDTH-1];
    assign aMag     = aNeg ? -a_i : a_i;
    assign bMag     = bNeg ? -b_i : b_i;

    // Multiply: LSB-first shift-add with the multiplicand shifted left each step.
    assign mulSum = acc_q + (opB_q[0] ? mcand_q : '0);

    // Divide: acc holds {remainder, remaining dividend bits / quotient bits}.
    assign remCand = acc_q[2*WIDTH-1:WIDTH-1];
    assign remDiff = remCand - {1'b0, opB_q};
    assign divNext = remDiff[WIDTH]
                   ? {remCand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {remDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prodRes      = negRes_q ? -acc_q : acc_q;
    assign quotRes      = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remRes       = negA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign dividendOrig = negA_q ? -mcand_q[WIDTH-1:0] : mcand_q[WIDTH-1:0];

`ifdef MUL_DIV_EARLY_OUT_EN
    assign lastStep = (count_q == LAST) | (~isDiv_q & ((opB_q >> 1) == '0));
`else
    assign lastStep = (count_q == LAST);
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opB_d    = opB_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negA_d   = negA_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    state_d  = RUN;
                    count_d  = '0;
                    isDiv_d  = op_i[1];
                    negRes_d = aNeg ^ bNeg;
                    negA_d   = aNeg;
                    opB_d    = bMag;
                    mcand_d  = {{WIDTH{1'b0}}, aMag};
                    acc_d    = op_i[1] ? {{WIDTH{1'b0}}, aMag} : '0;
                end
            end
            RUN: begin
                if (isDiv_q) begin
                    acc_d = divNext;
                end else begin
                    acc_d   = mulSum;
                    mcand_d = mcand_q << 1;
                    opB_d   = opB_q >> 1;
                end
                count_d = count_q + 1'b1;
                if (lastStep) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!isDiv_q) begin
                    hi_d = prodRes[2*WIDTH-1:WIDTH];
                    lo_d = prodRes[WIDTH-1:0];
                end else if (opB_q == '0) begin
                    // Divide by zero returns the original dividend and an all-ones quotient.
                    hi_d = dividendOrig;
                    lo_d = '1;
                end else begin
                    hi_d = remRes;
                    lo_d = quotRes;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opB_q    <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negA_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opB_q    <= opB_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negA_q   <= negA_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and random ops against an arithmetic model.
// Honours `MUL_DIV_EARLY_OUT_EN for the expected multiply latency.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'd0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         hi_we_i = 1'b0;
    logic         lo_we_i = 1'b0;
    logic [W-1:0] wdata_i = '0;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    int total = 0;
    int bad = 0;
    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .hi_we_i (hi_we_i),
        .lo_we_i (lo_we_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference results straight from signed/unsigned 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint p, sa, sb, q, r;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32]; lo = p[31:0];
            end
            2'd1: begin
                p = longint'({32'b0, a}) * longint'({32'b0, b});
                hi = p[63:32]; lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi = a; lo = '1;
                end else begin
                    sa = (op == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
                    sb = (op == 2'd2) ? longint'($signed(b)) : longint'({32'b0, b});
                    q = sa / sb;
                    r = sa % sb;
                    hi = r[31:0]; lo = q[31:0];
                end
            end
        endcase
    endfunction

    // Edges from the start edge (counted as 1) up to the edge that raises done.
    function automatic int expLatency(input logic [1:0] op, input logic [W-1:0] b);
        int lat;
        lat = 34;
`ifdef MUL_DIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [W-1:0] mag;
            int len;
            mag = (op == 2'd0 && b[W-1]) ? -b : b;
            len = 0;
            for (int i = 0; i < W; i++) if (mag[i]) len = i + 1;
            lat = 2 + ((len < 1) ? 1 : len);
        end
`endif
        return lat;
    endfunction

    // Issues one op at the current negedge and follows it to its done pulse.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit withMt, input int injectAt, input logic [W-1:0] mtData);
        logic [W-1:0] wantHi, wantLo;
        int edges;
        bit seen, holdOk, busyOk;
        model(op, a, b, wantHi, wantLo);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        if (withMt) begin
            hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = mtData;
            expHi = mtData; expLo = mtData;
        end
        @(posedge clk_i); @(negedge clk_i);
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        edges = 1;
        checkOutput("busy_after_start", {31'b0, busy_o}, 1);
        checkOutput("done_low_after_start", {31'b0, done_o}, 0);
        checkOutput("hi_after_start", hi_o, expHi);
        seen = 0; holdOk = 1; busyOk = 1;
        while (!seen && edges < 120) begin
            if (edges == injectAt) begin
                start_i = 1'b1; op_i = ~op; a_i = $urandom; b_i = $urandom;
                hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = $urandom;
            end else begin
                start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
            end
            @(posedge clk_i); @(negedge clk_i);
            edges++;
            if (done_o) seen = 1;
            else begin
                if (hi_o !== expHi || lo_o !== expLo) holdOk = 0;
                if (busy_o !== 1'b1) busyOk = 0;
            end
        end
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        checkOutput("done_timeout", {31'b0, seen}, 1);
        checkOutput("hilo_held_while_busy", {31'b0, holdOk}, 1);
        checkOutput("busy_held", {31'b0, busyOk}, 1);
        checkOutput("latency", W'(edges), W'(expLatency(op, b)));
        checkOutput("busy_at_done", {31'b0, busy_o}, 0);
        checkOutput("hi_result", hi_o, wantHi);
        checkOutput("lo_result", lo_o, wantLo);
        expHi = wantHi; expLo = wantLo;
    endtask

    initial begin
        logic [1:0] rop;
        logic [W-1:0] ra, rb;
        bit doneSeen;

        $display("[TB] start");
        repeat (2) @(negedge clk_i);
        checkOutput("reset_busy", {31'b0, busy_o}, 0);
        checkOutput("reset_done", {31'b0, done_o}, 0);
        checkOutput("reset_hi", hi_o, 0);
        checkOutput("reset_lo", lo_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
        @(posedge clk_i); @(negedge clk_i);
        hi_we_i = 1'b0;
        expHi = 32'h0000_1234;
        checkOutput("mthi_hi", hi_o, expHi);
        checkOutput("mthi_lo_untouched", lo_o, 0);

        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hCAFE_F00D;
        @(posedge clk_i); @(negedge clk_i);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        expHi = 32'hCAFE_F00D; expLo = 32'hCAFE_F00D;
        checkOutput("mt_both_hi", hi_o, expHi);
        checkOutput("mt_both_lo", lo_o, expLo);

        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, '0);
        checkOutput("mult_neg3x7_hi", hi_o, 32'hFFFF_FFFF);
        checkOutput("mult_neg3x7_lo", lo_o, 32'hFFFF_FFEB);
        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, '0);
        checkOutput("multu_max_hi", hi_o, 32'hFFFF_FFFE);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, '0);
        checkOutput("div_neg7_lo", lo_o, 32'hFFFF_FFFD);
        applyStimulus(3'd3, 32'd7, 32'd0, 0, 0, '0);
        checkOutput("divu_by0_hi", hi_o, 32'd7);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5, '0);
        checkOutput("div_ovf_lo", lo_o, 32'h8000_0000);
        applyStimulus(2'd1, 32'd5, 32'd3, 0, 0, '0);
        checkOutput("multu_5x3_lo", lo_o, 32'd15);
        applyStimulus(2'd2, 32'hFFFF_FFFB, 32'd0, 0, 0, '0);
        applyStimulus(2'd0, 32'h0000_0000, 32'h0001_2345, 1, 0, 32'hA5A5_A5A5);
        @(negedge clk_i);
        checkOutput("done_one_cycle", {31'b0, done_o}, 0);

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(0, 15));
                2: rb = -W'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : 0, $urandom);
            if ($urandom_range(0, 1) == 1) @(negedge clk_i);
        end

        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        @(posedge clk_i); @(negedge clk_i);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        op_i = 2'd0; a_i = 32'd1234; b_i = 32'd5678; start_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy_o}, 0);
        checkOutput("abort_hi", hi_o, 0);
        checkOutput("abort_lo", lo_o, 0);
        checkOutput("abort_done", {31'b0, done_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) doneSeen = 1;
        end
        checkOutput("abort_no_done", {31'b0, doneSeen}, 0);
        checkOutput("abort_hi_stays", hi_o, 0);
        checkOutput("abort_busy_stays", {31'b0, busy_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
